axil_pkt_sorter: RTL

- AXI4-Lite write-only slave that stages 32-bit packet words, then classifies each committed word by its tag byte.
- Words with tag == VALID_TAG go to the valid FIFO; all other words go to the invalid FIFO.
- Each FIFO has its own read port for downstream consumers.
- Parametrised successor of the fixed 8-deep packet validator: configurable width, depth and tag; proper AW/W/B handshake; flush; occupancy and error reporting.

---
 rtl/axil_pkt_pkg.sv | 17 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/axil_pkt_sorter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axil_pkt_pkg.sv
// Shared constants and FSM state type for the AXI4-Lite packet sorter.
package axil_pkt_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned ADDR_STAGE  = 'h00;
    localparam int unsigned ADDR_COMMIT = 'h04;
    localparam int unsigned ADDR_FLUSH  = 'h08;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data, occupancy count and flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = dout_q;

    always_comb begin
        // Flush wins over a pop; a pop frees the slot a push into a full FIFO needs.
        do_pop   = pop && !empty && !flush;
        do_push  = push && (!full || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                dout_d   = mem_q[rd_ptr_q];
            end
            count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/axil_pkt_sorter.sv
// AXI4-Lite write-only slave that stages packet words and sorts committed
// words into a valid or invalid FIFO by their tag byte.
module axil_pkt_sorter
    import axil_pkt_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DEPTH     = 8,
    parameter int unsigned       TAG_W     = 8,
    parameter logic [TAG_W-1:0]  VALID_TAG = TAG_W'(8'hA5)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   wvalid,
    output logic                   wready,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic                   val_rd_en,
    output logic [DATA_W-1:0]      val_rd_data,
    output logic [$clog2(DEPTH):0] val_count,
    output logic                   val_full,
    output logic                   val_empty,
    input  logic                   ival_rd_en,
    output logic [DATA_W-1:0]      ival_rd_data,
    output logic [$clog2(DEPTH):0] ival_count,
    output logic                   ival_full,
    output logic                   ival_empty,
    output logic                   err_pulse
);

    state_e              state_q, state_d;
    logic                aw_cap_q, aw_cap_d;
    logic                w_cap_q, w_cap_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   stage_q, stage_d;
    logic                staged_q, staged_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                err_q, err_d;

    logic                val_push, ival_push, fifo_flush;
    logic [TAG_W-1:0]    tag;
    logic                to_val, val_room, ival_room;

    assign tag       = stage_q[DATA_W-1 -: TAG_W];
    assign to_val    = (tag == VALID_TAG);
    // A same-cycle pop on a full FIFO makes room for the commit.
    assign val_room  = !val_full || (val_rd_en && !val_empty);
    assign ival_room = !ival_full || (ival_rd_en && !ival_empty);

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = (state_q == StResp);
    assign bresp     = bresp_q;
    assign err_pulse = err_q;

    always_comb begin
        state_d    = state_q;
        aw_cap_d   = aw_cap_q;
        w_cap_d    = w_cap_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        stage_d    = stage_q;
        staged_d   = staged_q;
        bresp_d    = bresp_q;
        err_d      = 1'b0;
        val_push   = 1'b0;
        ival_push  = 1'b0;
        fifo_flush = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (awvalid && awready_q) begin
                    aw_cap_d = 1'b1;
                    addr_d   = awaddr;
                end
                if (wvalid && wready_q) begin
                    w_cap_d = 1'b1;
                    wdata_d = wdata;
                end
                if (aw_cap_d && w_cap_d) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
                bresp_d = RESP_OKAY;
                if (addr_q == ADDR_W'(ADDR_STAGE)) begin
                    stage_d  = wdata_q;
                    staged_d = 1'b1;
                end else if (addr_q == ADDR_W'(ADDR_COMMIT)) begin
                    // A rejected commit keeps the staged word for a retry.
                    if (!staged_q || (to_val && !val_room) || (!to_val && !ival_room)) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        val_push  = to_val;
                        ival_push = !to_val;
                        staged_d  = 1'b0;
                    end
                end else if (addr_q == ADDR_W'(ADDR_FLUSH)) begin
                    fifo_flush = 1'b1;
                    staged_d   = 1'b0;
                end else begin
                    bresp_d = RESP_SLVERR;
                end
                err_d = (bresp_d == RESP_SLVERR);
            end
            StResp: begin
                if (bready) begin
                    state_d  = StIdle;
                    aw_cap_d = 1'b0;
                    w_cap_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        awready_d = (state_d == StIdle) && !aw_cap_d;
        wready_d  = (state_d == StIdle) && !w_cap_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            aw_cap_q  <= 1'b0;
            w_cap_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            stage_q   <= '0;
            staged_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_cap_q  <= aw_cap_d;
            w_cap_q   <= w_cap_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            stage_q   <= stage_d;
            staged_q  <= staged_d;
            bresp_q   <= bresp_d;
            err_q     <= err_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_val_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (val_push),
        .pop   (val_rd_en),
        .flush (fifo_flush),
        .din   (stage_q),
        .dout  (val_rd_data),
        .count (val_count),
        .full  (val_full),
        .empty (val_empty)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_ival_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ival_push),
        .pop   (ival_rd_en),
        .flush (fifo_flush),
        .din   (stage_q),
        .dout  (ival_rd_data),
        .count (ival_count),
        .full  (ival_full),
        .empty (ival_empty)
    );

endmodule
